// File: rtl/coeff_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// coeff_commit_ctrl_if
// Bundles the control/status signals of the coefficient commit controller.
//   clk_enable      : sample-rate enable qualifying every state update
//   i_write_done    : per-channel write-done levels from the input registers
//   i_phase         : current phase from the phase counter
//   i_ch_mask       : per-channel freeze (pending kept, commit suppressed)
//   i_clear_overrun : clears all sticky overrun flags
//   o_pending       : per-channel pending-commit flags
//   o_coeffs_en     : per-channel one-enabled-cycle commit pulse
//   o_overrun       : per-channel sticky overrun flags
//   o_busy          : OR of o_pending
//   o_commit_cnt    : wrapping count of commit events
// master drives the inputs of the controller; slave is the controller itself.
// ---------------------------------------------------------------------------
interface coeff_commit_ctrl_if #(
    parameter int N_CH    = 8,
    parameter int PHASE_W = 6,
    parameter int CNT_W   = 8
);
    logic               clk_enable;
    logic [N_CH-1:0]    i_write_done;
    logic [PHASE_W-1:0] i_phase;
    logic [N_CH-1:0]    i_ch_mask;
    logic               i_clear_overrun;
    logic [N_CH-1:0]    o_pending;
    logic [N_CH-1:0]    o_coeffs_en;
    logic [N_CH-1:0]    o_overrun;
    logic               o_busy;
    logic [CNT_W-1:0]   o_commit_cnt;

    modport master (
        output clk_enable, i_write_done, i_phase, i_ch_mask, i_clear_overrun,
        input  o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt
    );

    modport slave (
        input  clk_enable, i_write_done, i_phase, i_ch_mask, i_clear_overrun,
        output o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt
    );
endinterface

// File: rtl/coeff_commit_ctrl.sv
// ---------------------------------------------------------------------------
// coeff_commit_ctrl
// Captures per-band coefficient write-done rising edges as pending requests
// and, on the frame-boundary phase, commits every pending unmasked band at
// once by pulsing its coefficient enable for one enabled cycle. Tracks
// per-band overruns (a new write while still pending) and counts commit
// events.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : coeff_commit_ctrl_if.slave (enable, write-done, phase, mask,
//         overrun clear in; pending, commit pulse, overrun, busy, count out)
// ---------------------------------------------------------------------------
module coeff_commit_ctrl #(
    parameter int N_CH         = 8,
    parameter int PHASE_W      = 6,
    parameter int COMMIT_PHASE = 63,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    coeff_commit_ctrl_if.slave  bus
);

    localparam logic [PHASE_W-1:0] COMMIT_PHASE_V = PHASE_W'(COMMIT_PHASE);

    logic [N_CH-1:0]  wd_d_reg;
    logic [N_CH-1:0]  pending_reg;
    logic [N_CH-1:0]  coeffs_en_reg;
    logic [N_CH-1:0]  overrun_reg;
    logic [CNT_W-1:0] commit_cnt_reg;

    logic [N_CH-1:0]  edge_det;
    logic [N_CH-1:0]  do_commit;
    logic [N_CH-1:0]  pending_next;
    logic [N_CH-1:0]  overrun_next;
    logic             commit_cycle;

    assign commit_cycle = (bus.i_phase == COMMIT_PHASE_V);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign edge_det[gi]  = bus.i_write_done[gi] & ~wd_d_reg[gi];
            assign do_commit[gi] = commit_cycle & pending_reg[gi] & ~bus.i_ch_mask[gi];

            // A fresh edge always (re)arms the request, even in the commit
            // cycle: that write missed this frame and goes out with the next.
            assign pending_next[gi] = edge_det[gi]  ? 1'b1 :
                                      do_commit[gi] ? 1'b0 :
                                                      pending_reg[gi];

            // Setting takes priority over the clear so a coincident overrun
            // is never lost.
            assign overrun_next[gi] = (edge_det[gi] & pending_reg[gi] & ~do_commit[gi]) ? 1'b1 :
                                      bus.i_clear_overrun ? 1'b0 :
                                                            overrun_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_d_reg       <= '0;
            pending_reg    <= '0;
            coeffs_en_reg  <= '0;
            overrun_reg    <= '0;
            commit_cnt_reg <= '0;
        end else if (bus.clk_enable) begin
            wd_d_reg      <= bus.i_write_done;
            pending_reg   <= pending_next;
            coeffs_en_reg <= do_commit;
            overrun_reg   <= overrun_next;
            // One event per commit cycle, however many bands go out.
            if (|do_commit) begin
                commit_cnt_reg <= commit_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.o_pending    = pending_reg;
    assign bus.o_coeffs_en  = coeffs_en_reg;
    assign bus.o_overrun    = overrun_reg;
    assign bus.o_busy       = |pending_reg;
    assign bus.o_commit_cnt = commit_cnt_reg;

endmodule

// File: doc/coeff_commit_ctrl.md
Name: coeff_commit_ctrl

Overview:
Multi-channel, parametrised successor to the single-band write-done capture logic. It detects per-band coefficient write-done rising edges and holds each as a pending request. At the frame-boundary phase it commits every pending, unmasked band in one enabled cycle by pulsing that band's coefficient-enable. It sits between the per-band input registers and the per-band coefficient banks of the equalizer, driven by the phase counter. It also reports overruns and keeps a commit-event count.

Parameters:
N_CH, 8, number of bands/channels (1..32)
PHASE_W, 6, width of phase counter input
COMMIT_PHASE, 63, phase value on which commits occur (must be < 2**PHASE_W)
CNT_W, 8, width of commit-event counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
clk_enable  input  1  sample-rate enable; all state updates only when high
i_write_done  input  N_CH  per-channel write-done level from the input registers
i_phase  input  PHASE_W  current phase from the phase counter
i_ch_mask  input  N_CH  1 = channel frozen: pending kept, commit suppressed
i_clear_overrun  input  1  clears all overrun flags (enabled cycle)
o_pending  output  N_CH  per-channel pending-commit flags
o_coeffs_en  output  N_CH  registered one-enabled-cycle commit pulse per channel
o_overrun  output  N_CH  sticky flag: new write while channel already pending
o_busy  output  1  OR of o_pending
o_commit_cnt  output  CNT_W  count of commit events, wraps modulo 2**CNT_W

Behaviour:
- Reset (asynchronous): all internal registers and all outputs are 0.
- Every update below occurs on posedge clk only when clk_enable=1. When clk_enable=0, all registers hold, and o_coeffs_en holds its value.
- Edge detect: wd_d[ch] <= i_write_done[ch]. Edge is defined as edge[ch] = i_write_done[ch] & ~wd_d[ch]. A level held high produces exactly one edge.
- commit_cycle = (i_phase == COMMIT_PHASE).
- do_commit[ch] = commit_cycle & pending[ch] & ~i_ch_mask[ch].
- Pending next state:
  - If do_commit[ch] and no edge[ch]: pending <= 0.
  - If edge[ch] (including during a commit cycle): pending <= 1. An edge coincident with a commit is not committed this frame and stays pending for the next frame.
  - Otherwise pending holds.
- o_coeffs_en[ch] <= do_commit[ch].
  - One enabled-cycle latency from the commit phase; the pulse occurs on the enabled cycle after i_phase == COMMIT_PHASE.
  - It is 0 on every other enabled cycle.
- Overrun:
  - Set when edge[ch] & pending[ch] & ~do_commit[ch].
  - Cleared when i_clear_overrun=1.
  - If set and clear occur in the same cycle, set wins.
  - Overrun does not alter pending, which is already 1.
- Masked channels keep pending indefinitely. Overrun still applies to them. The first commit cycle after unmask commits them.
- o_commit_cnt increments by 1 on an enabled cycle where |do_commit = 1, regardless of how many channels commit. It wraps from 2**CNT_W-1 to 0.
- o_busy is combinational OR of pending.
- Reset mid-frame drops all pending requests and overrun flags. No coeffs_en pulse follows.

Test Plan:
1. Reset, clk_enable=1, pulse i_write_done[2] high at phase 10 → o_pending=8'h04. At phase 63, o_coeffs_en=8'h04 on the next enabled cycle. Pending then clears and o_commit_cnt=1.
2. Edges on ch0 at phase 5 and ch7 at phase 40 → a single commit event with o_coeffs_en=8'h81 for one cycle. o_commit_cnt increments by exactly 1.
3. Edge on ch1 coinciding with phase 63 while ch1 is not pending → no pulse this frame. o_pending[1]=1 and the pulse arrives after the next phase 63. o_overrun[1]=0.
4. Two edges on ch3 within one frame → o_overrun[3]=1 and a single commit pulse. Assert i_clear_overrun → o_overrun[3]=0. Clear asserted on the same cycle as a new overrun edge → stays 1.
5. i_ch_mask=8'h10 with ch4 pending across 3 frames → no pulse while masked and o_busy=1. Unmask → pulse at the next phase 63.
6. clk_enable toggling 1-of-4 during a commit → pulse lasts exactly one enabled period. Assert rst while pending=8'hFF → all outputs 0 immediately and no pulse after release. Also run 256 commit events → o_commit_cnt wraps to 0.
